// File: rtl/pipeline_stage_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_stage_skid_reg                                         |
// | Purpose  : Generic inter-stage pipeline register with a 2-entry skid       |
// |            buffer. Payload moves under a valid/ready handshake. in_ready_o |
// |            is registered, so it does not depend combinationally on         |
// |            out_ready_i. Supports flush (bubble insertion) and sustains one |
// |            payload per cycle.                                              |
// | Ports    : clk, rst (sync, active-high), flush_i                           |
// |            in_valid_i / in_ready_o / in_data_i    upstream handshake       |
// |            out_valid_o / out_ready_i / out_data_o downstream handshake     |
// |            stall_cnt_o, flush_cnt_o               perf counters (optional) |
// | Options  : define PIPE_REG_PERF_EN to add the saturating stall and flush   |
// |            counters together with the CNT_W parameter.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipeline_stage_skid_reg #(
  parameter int          DATA_W    = 64,
  parameter logic [63:0] NOP_VALUE = {32'b0, 32'h13}
`ifdef PIPE_REG_PERF_EN
  , parameter int        CNT_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_REG_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt_o
  , output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  // Bubble payload, zero-extended or truncated to the payload width.
  localparam logic [DATA_W-1:0] C_NOP = DATA_W'(NOP_VALUE);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;

  logic w_accept;
  logic w_drain;

  // The skid entry is only occupied when main is full, so an empty skid
  // always has room for one more payload; that makes !skid_v a safe ready.
  assign in_ready_o = !skid_v_q;
  assign w_accept   = in_valid_i && !skid_v_q;
  assign w_drain    = main_v_q && out_ready_i;

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush_i) begin
      // Any payload accepted this cycle is dropped along with held entries.
      main_v_d = 1'b0;
      main_d_d = C_NOP;
      skid_v_d = 1'b0;
    end else if (!main_v_q || w_drain) begin
      if (skid_v_q) begin
        // Older skid entry moves up first; accept is impossible while skid_v.
        main_v_d = 1'b1;
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
      end else if (w_accept) begin
        main_v_d = 1'b1;
        main_d_d = in_data_i;
      end else begin
        // Parking the bubble value keeps out_data_o registered and NOP when idle.
        main_v_d = 1'b0;
        main_d_d = C_NOP;
      end
    end else if (w_accept) begin
      skid_v_d = 1'b1;
      skid_d_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_d_q <= C_NOP;
      skid_v_q <= 1'b0;
      skid_d_q <= C_NOP;
    end else begin
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign out_valid_o = main_v_q;
  assign out_data_o  = main_d_q;

`ifdef PIPE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic w_stall;
  logic w_flush_kill;

  assign w_stall      = main_v_q && !out_ready_i;
  // Only flushes that actually discard a held payload are interesting.
  assign w_flush_kill = flush_i && (main_v_q || skid_v_q);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (w_flush_kill && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipeline_stage_skid_reg                                      |
// | Purpose  : Self-checking bench for pipeline_stage_skid_reg. A queue-based  |
// |            model (a FIFO of capacity two) supplies the expected outputs.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipeline_stage_skid_reg;

  localparam logic [63:0] C_NOP = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_data_o;
`ifdef PIPE_REG_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: the stage holds at most two payloads in arrival order.
  logic [63:0] mq[$];
  int          m_stall;
  int          m_flush;

  always #5 clk = ~clk;

  pipeline_stage_skid_reg #(
    .DATA_W    (64),
    .NOP_VALUE (64'h13)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt_o (stall_cnt_o)
    , .flush_cnt_o (flush_cnt_o)
`endif
  );

  // Advance one clock and apply the same transfer rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (mq.size() > 0 && !out_ready_i) m_stall++;
      if (flush_i) begin
        if (mq.size() > 0) m_flush++;
        mq.delete();
      end else begin
        bit acc;
        acc = in_valid_i && (mq.size() < 2);
        if (mq.size() > 0 && out_ready_i) void'(mq.pop_front());
        if (acc) mq.push_back(in_data_i);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
    step();
    step();
    rst = 1'b0;
    tests_run++;
    if (out_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid_o);
    end
    tests_run++;
    if (out_data_o !== C_NOP) begin
      tests_failed++; $display("FAIL reset_data: got %h want %h", out_data_o, C_NOP);
    end
    tests_run++;
    if (in_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 1", in_ready_o);
    end
  endtask

  task automatic test_streaming();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data_i = 64'(i);
      step();
      tests_run++;
      if (out_valid_o !== 1'b1 || out_data_o !== 64'(i) || in_ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, out_valid_o, out_data_o, in_ready_o, 64'(i));
      end
    end
    in_valid_i = 1'b0;
    in_data_i  = 'x;
    step();
    tests_run++;
    if (out_valid_o !== 1'b0 || out_data_o !== C_NOP) begin
      tests_failed++;
      $display("FAIL stream_idle: got v=%b d=%h want v=0 d=%h", out_valid_o, out_data_o, C_NOP);
    end
  endtask

  task automatic test_stall_skid();
    logic [63:0] src[$];
    logic [63:0] got[$];
    int          cyc;
    src = '{64'hA, 64'hB, 64'hC};
    out_ready_i = 1'b0;
    // Offer A, B, C back to back while downstream is stalled.
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = src[0];
      if (in_ready_o) void'(src.pop_front());
      step();
    end
    tests_run++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hA || in_ready_o !== 1'b0 || src.size() != 1) begin
      tests_failed++;
      $display("FAIL skid_full: got v=%b d=%h r=%b pending=%0d want v=1 d=a r=0 pending=1",
               out_valid_o, out_data_o, in_ready_o, src.size());
    end
    // Release and collect everything that leaves the stage.
    out_ready_i = 1'b1;
    cyc = 0;
    while (got.size() < 3 && cyc < 20) begin
      in_valid_i = (src.size() > 0);
      in_data_i  = (src.size() > 0) ? src[0] : 'x;
      if (out_valid_o && out_ready_i) got.push_back(out_data_o);
      if (in_valid_i && in_ready_o) void'(src.pop_front());
      step();
      cyc++;
    end
    in_valid_i = 1'b0;
    tests_run++;
    if (got.size() != 3) begin
      tests_failed++; $display("FAIL skid_count: got %0d payloads want 3", got.size());
    end else begin
      tests_run++;
      if (got[0] !== 64'hA || got[1] !== 64'hB || got[2] !== 64'hC) begin
        tests_failed++;
        $display("FAIL skid_order: got %h %h %h want a b c", got[0], got[1], got[2]);
      end
    end
    step();
    tests_run++;
    if (out_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL skid_dup: got v=%b d=%h want v=0", out_valid_o, out_data_o);
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 64'hA; step();
    in_data_i = 64'hB; step();
    flush_i = 1'b1; in_data_i = 64'hC; step();
    flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = 'x;
    tests_run++;
    if (out_valid_o !== 1'b0 || out_data_o !== C_NOP || in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_state: got v=%b d=%h r=%b want v=0 d=%h r=1",
               out_valid_o, out_data_o, in_ready_o, C_NOP);
    end
    out_ready_i = 1'b1;
    step();
    step();
    tests_run++;
    if (out_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_drop: got v=%b d=%h want v=0", out_valid_o, out_data_o);
    end
  endtask

  task automatic test_mid_reset();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 64'h11; step();
    in_data_i = 64'h22; step();
    in_valid_i = 1'b0; in_data_i = 'x;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    tests_run++;
    if (out_valid_o !== 1'b0 || out_data_o !== C_NOP || in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_state: got v=%b d=%h r=%b want v=0 d=%h r=1",
               out_valid_o, out_data_o, in_ready_o, C_NOP);
    end
`ifdef PIPE_REG_PERF_EN
    tests_run++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrst_cnt: got stall=%0d flush=%0d want 0 0", stall_cnt_o, flush_cnt_o);
    end
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      in_data_i   = in_valid_i ? {$urandom, $urandom} : 'x;
      step();
      tests_run++;
      if (out_valid_o !== (mq.size() > 0) ||
          out_data_o  !== ((mq.size() > 0) ? mq[0] : C_NOP) ||
          in_ready_o  !== (mq.size() < 2)) begin
        tests_failed++;
        errs++;
        if (errs <= 5)
          $display("FAIL rand_%0d: got v=%b d=%h r=%b want v=%b d=%h r=%b", i,
                   out_valid_o, out_data_o, in_ready_o, (mq.size() > 0),
                   ((mq.size() > 0) ? mq[0] : C_NOP), (mq.size() < 2));
      end
`ifdef PIPE_REG_PERF_EN
      tests_run++;
      if (stall_cnt_o !== 32'(m_stall) || flush_cnt_o !== 32'(m_flush)) begin
        tests_failed++;
        errs++;
        if (errs <= 5)
          $display("FAIL rand_cnt_%0d: got stall=%0d flush=%0d want %0d %0d", i,
                   stall_cnt_o, flush_cnt_o, m_stall, m_flush);
      end
`endif
    end
    flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = 'x;
  endtask

`ifdef PIPE_REG_PERF_EN
  task automatic test_perf();
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; step(); rst = 1'b0;
    in_valid_i = 1'b1; in_data_i = 64'h1; step();
    in_valid_i = 1'b0; in_data_i = 'x;
    repeat (5) step();
    out_ready_i = 1'b1; flush_i = 1'b1; step();
    flush_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h2; step();
    in_valid_i = 1'b0; in_data_i = 'x; flush_i = 1'b1; step();
    step();
    flush_i = 1'b0;
    tests_run++;
    if (stall_cnt_o !== 32'd5) begin
      tests_failed++; $display("FAIL perf_stall: got %0d want 5", stall_cnt_o);
    end
    tests_run++;
    if (flush_cnt_o !== 32'd2) begin
      tests_failed++; $display("FAIL perf_flush: got %0d want 2", flush_cnt_o);
    end
  endtask
`endif

  initial begin
    m_stall = 0;
    m_flush = 0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_mid_reset();
    test_random();
`ifdef PIPE_REG_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
